// File: rtl/mem_responder.sv
// Single-port word memory target with a valid/ready request/response handshake
// and a fixed number of wait states between request acceptance and response.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_WAIT   = 2'd1;
  localparam logic [1:0]  ST_RESP   = 2'd2;
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]  WAIT_LOAD = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]  state_r;
  logic [3:0]  cnt_r;
  logic        lat_we_r;
  logic [3:0]  lat_be_r;
  logic [31:0] lat_addr_r;
  logic [31:0] lat_wdata_r;
  logic [31:0] mem_r [DEPTH_WORDS];

  logic          accept_s;
  logic          exec_s;
  logic          ex_we_s;
  logic [3:0]    ex_be_s;
  logic [31:0]   ex_addr_s;
  logic [31:0]   ex_wdata_s;
  logic [31:0]   off_s;
  logic          err_s;
  logic [AW-1:0] idx_s;

  // Select the transaction that executes on this edge and decode its address
  always_comb begin
    accept_s = ce && (state_r == ST_IDLE) && req_ready && req_valid;
    if (ZERO_WAIT) begin
      exec_s     = accept_s;
      ex_we_s    = req_we;
      ex_be_s    = req_be;
      ex_addr_s  = req_addr;
      ex_wdata_s = req_wdata;
    end else begin
      exec_s     = ce && (state_r == ST_WAIT) && (cnt_r == 4'd0);
      ex_we_s    = lat_we_r;
      ex_be_s    = lat_be_r;
      ex_addr_s  = lat_addr_r;
      ex_wdata_s = lat_wdata_r;
    end
    // BASE_ADDR is word-aligned, so the low offset bits equal the low address bits
    off_s = ex_addr_s - BASE_ADDR;
    err_s = (|off_s[31:AW+2]) || (off_s[1:0] != 2'b00);
    idx_s = off_s[AW+1:2];
  end

  // Memory array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (reset && exec_s && ex_we_s && !err_s) begin
      for (int b = 0; b < 4; b++) begin
        if (ex_be_s[b]) begin
          mem_r[idx_s][8*b +: 8] <= ex_wdata_s[8*b +: 8];
        end
      end
    end
  end

  // Handshake sequencing, wait-state counting and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      lat_we_r    <= 1'b0;
      lat_be_r    <= 4'd0;
      lat_addr_r  <= 32'd0;
      lat_wdata_r <= 32'd0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'd0;
      rsp_err     <= 1'b0;
    end else if (ce) begin
      case (state_r)
        ST_IDLE: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            lat_we_r    <= req_we;
            lat_be_r    <= req_be;
            lat_addr_r  <= req_addr;
            lat_wdata_r <= req_wdata;
            req_ready   <= 1'b0;
            cnt_r       <= WAIT_LOAD;
            state_r     <= ZERO_WAIT ? ST_RESP : ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= 4'd0;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b0;
        end
      endcase
      // Execute edge: the read sees the word as it was before this edge
      if (exec_s) begin
        rsp_valid <= 1'b1;
        rsp_err   <= err_s;
        rsp_rdata <= (err_s || ex_we_s) ? 32'd0 : mem_r[idx_s];
      end
    end
  end

endmodule
